// File: rtl/ahb_sram_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module  : ahb_sram_ctrl_v2
// Brief   : AHB-Lite slave in front of a single-port synchronous SRAM macro,
//           with a deferred-write buffer, read-after-write merge, configurable
//           read latency and a two-cycle ERROR response for illegal transfers.
// Rev     : 2.0  generalised data width, read wait states, ERROR response
// ============================================================================
module ahb_sram_ctrl_v2 #(
    parameter int DW     = 64,
    parameter int AW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic            HREADY,
    input  logic [1:0]      HTRANS,
    input  logic [2:0]      HSIZE,
    input  logic            HWRITE,
    input  logic [31:0]     HADDR,
    input  logic [DW-1:0]   HWDATA,
    output logic            HREADYOUT,
    output logic [1:0]      HRESP,
    output logic [DW-1:0]   HRDATA,
    input  logic [DW-1:0]   SRAMRDATA,
    output logic [DW/8-1:0] SRAMWEN,
    output logic [DW-1:0]   SRAMWDATA,
    output logic            SRAMCS,
    output logic [AW-1:0]   SRAMADDR
);

    localparam int NB = DW / 8;
    localparam int BO = $clog2(NB);
    localparam logic [1:0] c_CNT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RWAIT = 3'd1,
        S_RDONE = 3'd2,
        S_WDATA = 3'd3,
        S_ERR1  = 3'd4,
        S_ERR2  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    state_t          w_acc_state;
    logic [1:0]      r_cnt;
    logic [1:0]      w_cnt_nxt;

    logic            r_buf_pend;
    logic            r_buf_data_en;
    logic [NB-1:0]   r_buf_we;
    logic [AW-1:0]   r_buf_addr;
    logic [DW-1:0]   r_buf_data;
    logic            r_hit;

    logic            w_acc;
    logic            w_size_bad;
    logic [7:0]      w_align_mask;
    logic            w_misalign;
    logic            w_bad;
    logic            w_illegal;
    logic            w_rd_acc;
    logic            w_wr_acc;
    logic            w_ram_write;
    logic            w_hit;
    logic [BO-1:0]   w_off;
    logic [AW-1:0]   w_word;
    logic [NB-1:0]   w_lane_we;
    logic            w_unused;

    // Reset gates the SRAM port so a pending write is dropped, not committed.
    assign w_acc        = HSEL & HREADY & HTRANS[1] & ~HRESET;
    assign w_size_bad   = (HSIZE > 3'(BO));
    assign w_align_mask = 8'((9'd1 << HSIZE) - 9'd1);
    assign w_misalign   = |(HADDR[7:0] & w_align_mask);
    assign w_bad        = w_size_bad | w_misalign;
    assign w_illegal    = w_acc & w_bad;
    assign w_rd_acc     = w_acc & ~w_bad & ~HWRITE;
    assign w_wr_acc     = w_acc & ~w_bad & HWRITE;
    assign w_off        = HADDR[BO-1:0];
    assign w_word       = HADDR[AW+BO-1:BO];
    assign w_unused     = ^{HADDR[31:AW+BO], HTRANS[0]};

    // A lane belongs to the access when it falls in the same 2^HSIZE group.
    always_comb begin
        w_lane_we = '0;
        for (int i = 0; i < NB; i++) begin
            w_lane_we[i] = ((BO'(i) >> HSIZE) == (w_off >> HSIZE));
        end
    end

    assign w_ram_write = (r_buf_pend | r_buf_data_en) & ~w_rd_acc & ~HRESET;
    assign SRAMWEN     = {NB{w_ram_write}} & r_buf_we;
    assign SRAMWDATA   = r_buf_pend ? r_buf_data : HWDATA;
    assign SRAMADDR    = w_rd_acc ? w_word : r_buf_addr;
    assign SRAMCS      = w_rd_acc | w_ram_write;
    assign w_hit       = w_rd_acc & (w_word == r_buf_addr) & (r_buf_pend | r_buf_data_en);

    always_comb begin
        HRDATA = SRAMRDATA;
        for (int i = 0; i < NB; i++) begin
            if (r_hit && r_buf_we[i]) begin
                HRDATA[8*i +: 8] = r_buf_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 2'd0;
        HREADYOUT   = 1'b1;
        HRESP       = 2'b00;
        if (w_illegal) begin
            w_acc_state = S_ERR1;
        end else if (HWRITE) begin
            w_acc_state = S_WDATA;
        end else if (RD_LAT == 1) begin
            w_acc_state = S_RDONE;
        end else begin
            w_acc_state = S_RWAIT;
        end
        case (r_state)
            S_RWAIT: begin
                HREADYOUT = 1'b0;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_RDONE;
                end else begin
                    w_cnt_nxt = 2'(r_cnt + 2'd1);
                end
            end
            S_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 2'b01;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                HRESP       = 2'b01;
                w_state_nxt = w_acc ? w_acc_state : S_IDLE;
            end
            default: begin
                w_state_nxt = w_acc ? w_acc_state : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_buf_pend    <= 1'b0;
            r_buf_data_en <= 1'b0;
            r_buf_we      <= '0;
            r_buf_addr    <= '0;
            r_hit         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            // A read always wins the port; the buffered write waits one more cycle.
            r_buf_pend    <= (r_buf_pend | r_buf_data_en) & w_rd_acc;
            r_buf_data_en <= w_wr_acc;
            if (w_wr_acc) begin
                r_buf_addr <= w_word;
                r_buf_we   <= w_lane_we;
            end
            if (w_acc) begin
                r_hit <= w_hit;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < NB; i++) begin
            if (r_buf_data_en && r_buf_we[i]) begin
                r_buf_data[8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_ctrl_v2.sv
`default_nettype none
// Directed bench for ahb_sram_ctrl_v2: three instances (64b/lat1, 64b/lat3,
// 32b/lat1), each with a behavioural SRAM model.
module tb_ahb_sram_ctrl_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        sel_a, sel_b, sel_c;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [63:0] hwdata;

    logic        hreadyout_a, hready_a, cs_a;
    logic [1:0]  hresp_a;
    logic [63:0] hrdata_a, rd_a, wdata_a;
    logic [7:0]  wen_a;
    logic [8:0]  addr_a;

    logic        hreadyout_b, hready_b, cs_b;
    logic [1:0]  hresp_b;
    logic [63:0] hrdata_b, wdata_b, q1_b, q2_b, q3_b;
    logic [7:0]  wen_b;
    logic [8:0]  addr_b;

    logic        hreadyout_c, hready_c, cs_c;
    logic [1:0]  hresp_c;
    logic [31:0] hrdata_c, rd_c, wdata_c;
    logic [3:0]  wen_c;
    logic [8:0]  addr_c;

    logic [63:0] mem_a [0:511];
    logic [63:0] mem_b [0:511];
    logic [31:0] mem_c [0:511];

    int n_err;
    int n_chk;

    always #5 clk = ~clk;

    assign hready_a = hreadyout_a;
    assign hready_b = hreadyout_b;
    assign hready_c = hreadyout_c;

    ahb_sram_ctrl_v2 #(.DW(64), .AW(9), .RD_LAT(1)) u_dut_a (
        .HCLK(clk), .HRESET(rst), .HSEL(sel_a), .HREADY(hready_a),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
        .HWDATA(hwdata), .HREADYOUT(hreadyout_a), .HRESP(hresp_a),
        .HRDATA(hrdata_a), .SRAMRDATA(rd_a), .SRAMWEN(wen_a),
        .SRAMWDATA(wdata_a), .SRAMCS(cs_a), .SRAMADDR(addr_a)
    );

    ahb_sram_ctrl_v2 #(.DW(64), .AW(9), .RD_LAT(3)) u_dut_b (
        .HCLK(clk), .HRESET(rst), .HSEL(sel_b), .HREADY(hready_b),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
        .HWDATA(hwdata), .HREADYOUT(hreadyout_b), .HRESP(hresp_b),
        .HRDATA(hrdata_b), .SRAMRDATA(q3_b), .SRAMWEN(wen_b),
        .SRAMWDATA(wdata_b), .SRAMCS(cs_b), .SRAMADDR(addr_b)
    );

    ahb_sram_ctrl_v2 #(.DW(32), .AW(9), .RD_LAT(1)) u_dut_c (
        .HCLK(clk), .HRESET(rst), .HSEL(sel_c), .HREADY(hready_c),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
        .HWDATA(hwdata[31:0]), .HREADYOUT(hreadyout_c), .HRESP(hresp_c),
        .HRDATA(hrdata_c), .SRAMRDATA(rd_c), .SRAMWEN(wen_c),
        .SRAMWDATA(wdata_c), .SRAMCS(cs_c), .SRAMADDR(addr_c)
    );

    // SRAM models: word k initialised to byte value k in every lane.
    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 512; k++) mem_a[k] <= 64'h0101010101010101 * 64'(k);
        end else if (cs_a) begin
            if (|wen_a) begin
                for (int i = 0; i < 8; i++)
                    if (wen_a[i]) mem_a[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
            end else begin
                rd_a <= mem_a[addr_a];
            end
        end
    end

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 512; k++) mem_b[k] <= 64'h0101010101010101 * 64'(k);
        end else if (cs_b) begin
            if (|wen_b) begin
                for (int i = 0; i < 8; i++)
                    if (wen_b[i]) mem_b[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
            end else begin
                q1_b <= mem_b[addr_b];
            end
        end
        q2_b <= q1_b;
        q3_b <= q2_b;
    end

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 512; k++) mem_c[k] <= 32'h01010101 * 32'(k);
        end else if (cs_c) begin
            if (|wen_c) begin
                for (int i = 0; i < 4; i++)
                    if (wen_c[i]) mem_c[addr_c][8*i +: 8] <= wdata_c[8*i +: 8];
            end else begin
                rd_c <= mem_c[addr_c];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [2:0] sel, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a);
        {sel_c, sel_b, sel_a} = sel;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        {sel_c, sel_b, sel_a} = 3'b000;
        htrans = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_err  = 0;
        n_chk  = 0;
        rst    = 1'b1;
        load   = 1'b1;
        hwrite = 1'b0;
        hsize  = 3'd0;
        haddr  = 32'h0;
        hwdata = 64'h0;
        idle();
        tick();
        tick();
        load = 1'b0;
        #1;
        chk("rst_hreadyout_a", 64'(hreadyout_a), 64'd1);
        chk("rst_hresp_a",     64'(hresp_a),     64'd0);
        chk("rst_cs_a",        64'(cs_a),        64'd0);
        chk("rst_wen_a",       64'(wen_a),       64'd0);
        chk("rst_hreadyout_b", 64'(hreadyout_b), 64'd1);
        chk("rst_cs_c",        64'(cs_c),        64'd0);
        tick();
        rst = 1'b0;

        // 64-bit write then read, RD_LAT=1
        bus(3'b001, 1'b1, 3'd3, 32'h40);
        #1 chk("a_wr_addr_cs", 64'(cs_a), 64'd0);
        tick();
        hwdata = 64'h1122334455667788;
        idle();
        #1;
        chk("a_wr_wen",   64'(wen_a),   64'hFF);
        chk("a_wr_wdata", wdata_a,      64'h1122334455667788);
        chk("a_wr_addr",  64'(addr_a),  64'h8);
        tick();
        bus(3'b001, 1'b0, 3'd3, 32'h40);
        #1;
        chk("a_rd_cs",  64'(cs_a),  64'd1);
        chk("a_rd_wen", 64'(wen_a), 64'd0);
        tick();
        idle();
        #1;
        chk("a_rd_ready", 64'(hreadyout_a), 64'd1);
        chk("a_rd_data",  hrdata_a,         64'h1122334455667788);
        tick();

        // byte write 0xAB @0x43 followed at once by read @0x40
        bus(3'b001, 1'b1, 3'd0, 32'h43);
        tick();
        hwdata = 64'h00000000AB000000;
        bus(3'b001, 1'b0, 3'd3, 32'h40);
        #1;
        chk("a_mrg_rd_wen",  64'(wen_a),  64'd0);
        chk("a_mrg_rd_addr", 64'(addr_a), 64'h8);
        tick();
        idle();
        #1;
        chk("a_mrg_data",  hrdata_a,            64'h11223344AB667788);
        chk("a_mrg_drain", 64'(wen_a),          64'h08);
        chk("a_mrg_wbyte", 64'(wdata_a[31:24]), 64'hAB);
        tick();
        bus(3'b001, 1'b0, 3'd3, 32'h40);
        #1 chk("a_reread_wen", 64'(wen_a), 64'd0);
        tick();
        idle();
        #1 chk("a_reread_data", hrdata_a, 64'h11223344AB667788);
        tick();

        // misaligned halfword write -> ERROR
        bus(3'b001, 1'b1, 3'd1, 32'h41);
        #1 chk("a_err_cs0", 64'(cs_a), 64'd0);
        tick();
        idle();
        #1;
        chk("a_err1_ready", 64'(hreadyout_a), 64'd0);
        chk("a_err1_resp",  64'(hresp_a),     64'd1);
        chk("a_err1_cs",    64'(cs_a),        64'd0);
        tick();
        chk("a_err2_ready", 64'(hreadyout_a), 64'd1);
        chk("a_err2_resp",  64'(hresp_a),     64'd1);
        chk("a_err2_cs",    64'(cs_a),        64'd0);
        tick();
        chk("a_post_err_resp", 64'(hresp_a), 64'd0);

        // reset while a write is pending: it must be discarded
        bus(3'b001, 1'b1, 3'd0, 32'h48);
        tick();
        hwdata = 64'h00000000000000EE;
        bus(3'b001, 1'b0, 3'd3, 32'h00);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("a_rstp_wen",   64'(wen_a),       64'd0);
        chk("a_rstp_cs",    64'(cs_a),        64'd0);
        chk("a_rstp_ready", 64'(hreadyout_a), 64'd1);
        chk("a_rstp_resp",  64'(hresp_a),     64'd0);
        tick();
        bus(3'b001, 1'b0, 3'd3, 32'h48);
        tick();
        idle();
        #1 chk("a_rstp_old", hrdata_a, 64'h0909090909090909);
        tick();

        // RD_LAT=3: pending write drains during the read wait states
        bus(3'b010, 1'b1, 3'd3, 32'h10);
        tick();
        hwdata = 64'hCAFEBABE12345678;
        bus(3'b010, 1'b0, 3'd3, 32'h08);
        #1;
        chk("b_rd_wen",  64'(wen_b),  64'd0);
        chk("b_rd_addr", 64'(addr_b), 64'h1);
        chk("b_rd_cs",   64'(cs_b),   64'd1);
        tick();
        idle();
        #1;
        chk("b_w1_ready", 64'(hreadyout_b), 64'd0);
        chk("b_w1_wen",   64'(wen_b),       64'hFF);
        chk("b_w1_addr",  64'(addr_b),      64'h2);
        chk("b_w1_wdata", wdata_b,          64'hCAFEBABE12345678);
        tick();
        chk("b_w2_ready", 64'(hreadyout_b), 64'd0);
        chk("b_w2_wen",   64'(wen_b),       64'd0);
        tick();
        chk("b_done_ready", 64'(hreadyout_b), 64'd1);
        chk("b_done_data",  hrdata_b,         64'h0101010101010101);
        tick();
        bus(3'b010, 1'b0, 3'd3, 32'h10);
        tick();
        idle();
        #1 chk("b_rd2_wait", 64'(hreadyout_b), 64'd0);
        tick();
        tick();
        chk("b_rd2_ready", 64'(hreadyout_b), 64'd1);
        chk("b_rd2_data",  hrdata_b,         64'hCAFEBABE12345678);
        tick();

        // DW=32: oversize read -> ERROR; new transfer accepted in ERR2
        bus(3'b100, 1'b0, 3'd3, 32'h100);
        #1 chk("c_err_cs0", 64'(cs_c), 64'd0);
        tick();
        idle();
        #1;
        chk("c_err1_ready", 64'(hreadyout_c), 64'd0);
        chk("c_err1_resp",  64'(hresp_c),     64'd1);
        tick();
        bus(3'b100, 1'b1, 3'd2, 32'h104);
        #1;
        chk("c_err2_ready", 64'(hreadyout_c), 64'd1);
        chk("c_err2_resp",  64'(hresp_c),     64'd1);
        tick();
        hwdata = 64'h00000000DEADBEEF;
        idle();
        #1;
        chk("c_wr_addr",  64'(addr_c),  64'h41);
        chk("c_wr_wen",   64'(wen_c),   64'hF);
        chk("c_wr_wdata", 64'(wdata_c), 64'hDEADBEEF);
        chk("c_wr_resp",  64'(hresp_c), 64'd0);
        tick();
        bus(3'b100, 1'b1, 3'd1, 32'h106);
        tick();
        hwdata = 64'h0000000012340000;
        bus(3'b100, 1'b0, 3'd2, 32'h104);
        #1;
        chk("c_mrg_rd_wen", 64'(wen_c),  64'd0);
        chk("c_mrg_rd_cs",  64'(cs_c),   64'd1);
        chk("c_mrg_addr",   64'(addr_c), 64'h41);
        tick();
        idle();
        #1;
        chk("c_mrg_data",  64'(hrdata_c), 64'h1234BEEF);
        chk("c_mrg_drain", 64'(wen_c),    64'hC);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
